// File: rtl/sobel_win_ctrl_if.sv
// Scan-coordinate / threshold inputs and window-control outputs of sobel_win_ctrl.
// SOBEL_WIN_CTRL_STATS_EN adds the win_cnt statistics signal.
interface sobel_win_ctrl_if;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        thresh_wr;
  logic [15:0] thresh_in;
  logic        pic_en;
  logic [7:0]  col;
  logic [7:0]  row;
  logic        wr_bank;
  logic        win_valid;
  logic        line_start;
  logic        frame_start;
  logic        frame_done;
  logic [15:0] thresh;
`ifdef SOBEL_WIN_CTRL_STATS_EN
  logic [15:0] win_cnt;

  modport master (output pixel_x, pixel_y, thresh_wr, thresh_in,
                  input  pic_en, col, row, wr_bank, win_valid, line_start,
                         frame_start, frame_done, thresh, win_cnt);
  modport slave  (input  pixel_x, pixel_y, thresh_wr, thresh_in,
                  output pic_en, col, row, wr_bank, win_valid, line_start,
                         frame_start, frame_done, thresh, win_cnt);
`else
  modport master (output pixel_x, pixel_y, thresh_wr, thresh_in,
                  input  pic_en, col, row, wr_bank, win_valid, line_start,
                         frame_start, frame_done, thresh);
  modport slave  (input  pixel_x, pixel_y, thresh_wr, thresh_in,
                  output pic_en, col, row, wr_bank, win_valid, line_start,
                         frame_start, frame_done, thresh);
`endif
endinterface

// File: rtl/sobel_win_ctrl.sv
// Sobel 3x3 window scheduler: registered picture/window control from scan coordinates.
// Optional SOBEL_WIN_CTRL_STATS_EN: per-frame win_valid count on win_cnt.
module sobel_win_ctrl #(
  parameter logic [10:0] PIC_X_START    = 11'd200,
  parameter logic [10:0] PIC_Y_START    = 11'd100,
  parameter logic [10:0] PIC_WIDTH      = 11'd200,
  parameter logic [10:0] PIC_HEIGHT     = 11'd200,
  parameter logic [15:0] THRESH_DEFAULT = 16'd15625
) (
  input  logic             clk,
  input  logic             rst_n,
  sobel_win_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t      state_q;
  logic        pic_en_q, wr_bank_q, win_valid_q, line_start_q, frame_start_q, frame_done_q;
  logic [7:0]  col_q, row_q;
  logic [15:0] thresh_q, shadow_q;
`ifdef SOBEL_WIN_CTRL_STATS_EN
  logic [15:0] cnt_q, win_cnt_q;
`endif

  logic [10:0] dx, dy;
  logic        in_pic, at_origin, at_last, col_zero;
  logic [15:0] frame_thr;

  // Unsigned offsets: coordinates left/above the window wrap to large values.
  always_comb begin
    dx        = bus.pixel_x - PIC_X_START;
    dy        = bus.pixel_y - PIC_Y_START;
    in_pic    = (bus.pixel_x >= PIC_X_START) && (dx < PIC_WIDTH) &&
                (bus.pixel_y >= PIC_Y_START) && (dy < PIC_HEIGHT);
    at_origin = (bus.pixel_x == PIC_X_START) && (bus.pixel_y == PIC_Y_START);
    at_last   = in_pic && (dx == PIC_WIDTH - 11'd1) && (dy == PIC_HEIGHT - 11'd1);
    col_zero  = in_pic && (dx == '0);
    frame_thr = bus.thresh_wr ? bus.thresh_in : shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pic_en_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      wr_bank_q     <= 1'b0;
      win_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      thresh_q      <= THRESH_DEFAULT;
      shadow_q      <= THRESH_DEFAULT;
`ifdef SOBEL_WIN_CTRL_STATS_EN
      cnt_q         <= '0;
      win_cnt_q     <= '0;
`endif
    end else begin
      shadow_q      <= frame_thr;
      col_q         <= dx[7:0];
      row_q         <= dy[7:0];
      pic_en_q      <= 1'b0;
      win_valid_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      // The origin (re)starts a frame from IDLE, FILL or RUN alike.
      if (at_origin && (state_q != DONE)) begin
        state_q       <= FILL;
        pic_en_q      <= 1'b1;
        line_start_q  <= 1'b1;
        frame_start_q <= 1'b1;
        wr_bank_q     <= 1'b0;
        thresh_q      <= frame_thr;
`ifdef SOBEL_WIN_CTRL_STATS_EN
        cnt_q         <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          FILL, RUN: begin
            pic_en_q <= in_pic;
            if (col_zero) begin
              line_start_q <= 1'b1;
              wr_bank_q    <= ~wr_bank_q;
            end
            if (state_q == FILL) begin
              if (col_zero && (dy == 11'd2)) state_q <= RUN;
            end else begin
              win_valid_q <= in_pic && (dx >= 11'd2);
`ifdef SOBEL_WIN_CTRL_STATS_EN
              if (in_pic && (dx >= 11'd2)) cnt_q <= cnt_q + 16'd1;
`endif
              if (at_last) state_q <= DONE;
            end
          end
          DONE: begin
            pic_en_q     <= in_pic;
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
`ifdef SOBEL_WIN_CTRL_STATS_EN
            win_cnt_q    <= cnt_q;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pic_en      = pic_en_q;
  assign bus.col         = col_q;
  assign bus.row         = row_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.thresh      = thresh_q;
`ifdef SOBEL_WIN_CTRL_STATS_EN
  assign bus.win_cnt     = win_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Self-checking bench for sobel_win_ctrl: default 200x200, 6x5 and 3x3 instances
// driven with the same scan coordinates and compared to a per-pixel reference model.
module tb_sobel_win_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] px, py;
  logic        twr;
  logic [15:0] tin;

  sobel_win_ctrl_if ifa ();
  sobel_win_ctrl_if ifb ();
  sobel_win_ctrl_if ifc ();

  assign ifa.pixel_x = px;  assign ifa.pixel_y = py;  assign ifa.thresh_wr = twr;  assign ifa.thresh_in = tin;
  assign ifb.pixel_x = px;  assign ifb.pixel_y = py;  assign ifb.thresh_wr = twr;  assign ifb.thresh_in = tin;
  assign ifc.pixel_x = px;  assign ifc.pixel_y = py;  assign ifc.thresh_wr = twr;  assign ifc.thresh_in = tin;

  sobel_win_ctrl #(.PIC_X_START(11'd200), .PIC_Y_START(11'd100), .PIC_WIDTH(11'd200),
                   .PIC_HEIGHT(11'd200), .THRESH_DEFAULT(16'd15625))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  sobel_win_ctrl #(.PIC_WIDTH(11'd6), .PIC_HEIGHT(11'd5))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  sobel_win_ctrl #(.PIC_WIDTH(11'd3), .PIC_HEIGHT(11'd3))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  typedef struct packed {
    logic        pic_en;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        wr_bank;
    logic        win_valid;
    logic        line_start;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] thresh;
  } out_t;

  out_t obs [3];
  assign obs[0] = {ifa.pic_en, ifa.col, ifa.row, ifa.wr_bank, ifa.win_valid, ifa.line_start,
                   ifa.frame_start, ifa.frame_done, ifa.thresh};
  assign obs[1] = {ifb.pic_en, ifb.col, ifb.row, ifb.wr_bank, ifb.win_valid, ifb.line_start,
                   ifb.frame_start, ifb.frame_done, ifb.thresh};
  assign obs[2] = {ifc.pic_en, ifc.col, ifc.row, ifc.wr_bank, ifc.win_valid, ifc.line_start,
                   ifc.frame_start, ifc.frame_done, ifc.thresh};
`ifdef SOBEL_WIN_CTRL_STATS_EN
  logic [15:0] wcnt_obs [3];
  assign wcnt_obs[0] = ifa.win_cnt;
  assign wcnt_obs[1] = ifb.win_cnt;
  assign wcnt_obs[2] = ifc.win_cnt;
`endif

  localparam int XS = 200;
  localparam int YS = 100;
  int W [3] = '{200, 6, 3};
  int H [3] = '{200, 5, 3};

  // Reference model state: joined = inside a frame begun at the origin since reset.
  int m_join [3], m_done [3], m_wb [3], m_thr [3], m_sh [3], m_cnt [3], m_wcnt [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Bookkeeping of observed DUT behaviour, compared to bench constants at directed points.
  int   wv_cnt [3], pe_cnt [3], fs_cyc [3], fd_cyc [3], wv_last [3];
  int   bad_wv, org_cyc, last_cyc;
  logic [15:0] first_wv;
  bit   first_seen;
  logic bank_row [3];

  task automatic clear_book();
    for (int k = 0; k < 3; k++) begin
      wv_cnt[k] = 0; pe_cnt[k] = 0; fs_cyc[k] = -1; fd_cyc[k] = -1; wv_last[k] = -1;
      bank_row[k] = 1'bx;
    end
    bad_wv = 0; first_seen = 0; first_wv = '1; org_cyc = -1; last_cyc = -1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
    end
  endtask

  task automatic model_step(input int k, input int x, input int y, input logic rn,
                            input logic wr, input int tv, output out_t e);
    int c, r;
    bit inp;
    c   = x - XS;
    r   = y - YS;
    inp = (c >= 0) && (c < W[k]) && (r >= 0) && (r < H[k]);
    e   = '0;
    if (!rn) begin
      m_join[k] = 0; m_done[k] = 0; m_wb[k] = 0; m_thr[k] = 15625; m_sh[k] = 15625;
      m_cnt[k] = 0; m_wcnt[k] = 0;
    end else begin
      if (m_done[k] != 0) begin
        e.frame_done = 1'b1;
        e.pic_en     = inp;
        m_done[k]    = 0;
        m_wcnt[k]    = m_cnt[k];
      end else begin
        if (x == XS && y == YS) begin
          m_join[k] = 1; e.frame_start = 1'b1; m_cnt[k] = 0;
          m_thr[k]  = wr ? tv : m_sh[k];
        end
        if (m_join[k] != 0 && inp) begin
          e.pic_en = 1'b1;
          if (c == 0) begin e.line_start = 1'b1; m_wb[k] = r % 2; end
          if (r >= 2 && c >= 2) begin e.win_valid = 1'b1; m_cnt[k]++; end
          if (r == H[k] - 1 && c == W[k] - 1) begin m_join[k] = 0; m_done[k] = 1; end
        end
      end
      if (wr) m_sh[k] = tv;
    end
    e.col     = 8'(c);
    e.row     = 8'(r);
    e.wr_bank = m_wb[k][0];
    e.thresh  = 16'(m_thr[k]);
  endtask

  task automatic step(input int x, input int y, input logic wr, input int tv);
    out_t o, e;
    px = 11'(x); py = 11'(y); twr = wr; tin = 16'(tv);
    @(posedge clk);
    #1;
    cyc++;
    if (x == XS && y == YS) org_cyc = cyc;
    if (x == 399 && y == 299) last_cyc = cyc;
    for (int k = 0; k < 3; k++) begin
      model_step(k, x, y, rst_n, wr, tv, e);
      o = obs[k];
      if (!e.pic_en) begin o.col = '0; o.row = '0; e.col = '0; e.row = '0; end
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL cycle dut%0d cyc=%0d x=%0d y=%0d observed=%h expected=%h", k, cyc, x, y, o, e);
      end
`ifdef SOBEL_WIN_CTRL_STATS_EN
      checks++;
      assert (wcnt_obs[k] === 16'(m_wcnt[k])) else begin
        errors++;
        $error("FAIL win_cnt dut%0d cyc=%0d observed=%0d expected=%0d", k, cyc, wcnt_obs[k], m_wcnt[k]);
      end
`endif
      if (obs[k].win_valid === 1'b1) begin wv_cnt[k]++; wv_last[k] = cyc; end
      if (obs[k].pic_en === 1'b1) pe_cnt[k]++;
      if (obs[k].frame_start === 1'b1) fs_cyc[k] = cyc;
      if (obs[k].frame_done === 1'b1) fd_cyc[k] = cyc;
    end
    if (obs[0].win_valid === 1'b1) begin
      if (obs[0].col < 8'd2 || obs[0].row < 8'd2) bad_wv++;
      if (!first_seen) begin first_seen = 1; first_wv = {obs[0].row, obs[0].col}; end
    end
    if (obs[0].line_start === 1'b1 && obs[0].row < 8'd3) bank_row[obs[0].row[1:0]] = obs[0].wr_bank;
  endtask

  task automatic scan_rows(input int y0, input int y1, input int x0, input int x1, input int ext,
                           input int wy, input int wx, input int wv);
    int xe;
    for (int y = y0; y <= y1; y++) begin
      xe = x1 + int'($urandom_range(0, ext));
      for (int x = x0; x <= xe; x++) step(x, y, (y == wy && x == wx), wv);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 0);
  endtask

  localparam out_t RST_V = {1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd15625};

  initial begin
    int wy;
    rst_n = 1'b0; px = '0; py = '0; twr = 1'b0; tin = '0;
    clear_book();

    // Reset, including a threshold write that must be ignored.
    step(0, 0, 1'b0, 0);
    for (int k = 0; k < 3; k++) chk($sformatf("reset_dut%0d", k), 64'(obs[k]), 64'(RST_V));
    step(200, 100, 1'b1, 123);
    idle(2);
    rst_n = 1'b1;
    idle(int'($urandom_range(2, 6)));

    // Frame 1: full picture, random blanking, threshold write 5000 mid-frame.
    clear_book();
    wy = int'($urandom_range(150, 250));
    scan_rows(99, 300, 199, 400, 3, wy, 300, 5000);
    idle(3);
    chk("f1_frame_start_time", 64'(fs_cyc[0]), 64'(org_cyc));
    chk("f1_frame_done_time",  64'(fd_cyc[0]), 64'(last_cyc + 1));
    chk("f1_win_valid_count",  64'(wv_cnt[0]), 64'd39204);
    chk("f1_win_valid_bad",    64'(bad_wv),    64'd0);
    chk("f1_first_window",     64'(first_wv),  64'({8'd2, 8'd2}));
    chk("f1_bank_row0",        64'(bank_row[0]), 64'd0);
    chk("f1_bank_row1",        64'(bank_row[1]), 64'd1);
    chk("f1_bank_row2",        64'(bank_row[2]), 64'd0);
    chk("f1_thresh_held",      64'(obs[0].thresh), 64'd15625);
    chk("f1_6x5_win_count",    64'(wv_cnt[1]), 64'd12);
    chk("f1_3x3_win_count",    64'(wv_cnt[2]), 64'd1);
    chk("f1_3x3_done_after_win", 64'(fd_cyc[2]), 64'(wv_last[2] + 1));
`ifdef SOBEL_WIN_CTRL_STATS_EN
    chk("f1_win_cnt", 64'(wcnt_obs[0]), 64'd39204);
`endif

    // Frame 2: new threshold applies, then a glitch to (0,0) and a restart with a bypass write.
    clear_book();
    scan_rows(99, 179, 199, 260, 0, -1, -1, 0);
    for (int x = 199; x <= 250; x++) step(x, 180, 1'b0, 0);
    chk("f2_thresh_new", 64'(obs[0].thresh), 64'd5000);
    chk("f2_pic_en_before_jump", 64'(obs[0].pic_en), 64'd1);
    step(0, 0, 1'b0, 0);
    chk("f2_pic_en_after_jump", 64'(obs[0].pic_en), 64'd0);
    step(200, 100, 1'b1, 7000);
    chk("f3_restart_frame_start", 64'(obs[0].frame_start), 64'd1);
    chk("f3_restart_thresh_bypass", 64'(obs[0].thresh), 64'd7000);
    chk("f3_restart_wr_bank", 64'(obs[0].wr_bank), 64'd0);
    chk("f3_restart_pic_en", 64'(obs[0].pic_en), 64'd1);

    // Frame 3: reset mid-frame, released on row 150; the rest of the frame is ignored.
    scan_rows(101, 139, 199, 230, 2, 120, 210, int'($urandom_range(0, 65535)));
    rst_n = 1'b0;
    scan_rows(140, 149, 199, 230, 0, -1, -1, 0);
    rst_n = 1'b1;
    clear_book();
    scan_rows(150, 300, 199, 230, 2, -1, -1, 0);
    chk("f3_post_reset_pic_en", 64'(pe_cnt[0]), 64'd0);
    chk("f3_post_reset_win_valid", 64'(wv_cnt[0]), 64'd0);
    chk("f3_post_reset_thresh", 64'(obs[0].thresh), 64'd15625);
    idle(int'($urandom_range(1, 4)));

    // Frame 4: normal operation resumes from the next origin.
    clear_book();
    scan_rows(99, 103, 199, 262, 0, -1, -1, 0);
    chk("f4_frame_start_time", 64'(fs_cyc[0]), 64'(org_cyc));
    chk("f4_pic_en_count", 64'(pe_cnt[0]), 64'd252);
    chk("f4_win_valid_count", 64'(wv_cnt[0]), 64'd122);
    chk("f4_bank_row1", 64'(bank_row[1]), 64'd1);
    chk("f4_3x3_win_count", 64'(wv_cnt[2]), 64'd1);
    chk("f4_3x3_done_after_win", 64'(fd_cyc[2]), 64'(wv_last[2] + 1));
`ifdef SOBEL_WIN_CTRL_STATS_EN
    chk("f4_3x3_win_cnt", 64'(wcnt_obs[2]), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
